// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-SRAM write port of the boot image loader.
// The loader takes the master modport; the stream source / SRAM side takes slave.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  sram_en;
  logic [3:0]            sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_din;
  logic                  core_rst;
  logic                  load_done;
  logic                  load_err;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_din,
    output core_rst,
    output load_done,
    output load_err
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_din,
    input  core_rst,
    input  load_done,
    input  load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a header/data/checksum byte stream into 32-bit instruction SRAM
// writes and holds the core in reset until a complete, checksum-verified image is present.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    StHdr,
    StData,
    StWrite,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            sum_q;
  logic [1:0]            idx_q;
  logic [31:0]           word_q;

  logic                  byte_ready_q;
  logic                  sram_en_q;
  logic [3:0]            sram_we_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [31:0]           sram_din_q;
  logic                  core_rst_q;
  logic                  load_done_q;
  logic                  load_err_q;

  logic                  fire;
  logic [31:0]           word_next;

  // byte_ready is a flop, so the handshake has no combinational path from byte_valid
  assign fire = bus.byte_valid & byte_ready_q;

  // Little-endian lane insert of the incoming byte into the word being assembled
  always_comb begin
    word_next = word_q;
    unique case (idx_q)
      2'd0: word_next[7:0]   = bus.byte_data;
      2'd1: word_next[15:8]  = bus.byte_data;
      2'd2: word_next[23:16] = bus.byte_data;
      2'd3: word_next[31:24] = bus.byte_data;
      default: word_next = word_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHdr;
      count_q      <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b1;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 4'h0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sram_en_q <= 1'b0;
      sram_we_q <= 4'h0;
      unique case (state_q)
        StHdr: begin
          if (fire) begin
            count_q <= ADDR_WIDTH'(bus.byte_data);
            sum_q   <= bus.byte_data;
            addr_q  <= '0;
            idx_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (fire) begin
            word_q <= word_next;
            sum_q  <= sum_q + bus.byte_data;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              // Outputs are registered, so the write strobe is loaded on entry to StWrite
              state_q      <= StWrite;
              byte_ready_q <= 1'b0;
              sram_en_q    <= 1'b1;
              sram_we_q    <= 4'hF;
              sram_addr_q  <= addr_q;
              sram_din_q   <= word_next;
            end
          end
        end
        StWrite: begin
          byte_ready_q <= 1'b1;
          idx_q        <= '0;
          if (addr_q == count_q) begin
            state_q <= StChk;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= StData;
          end
        end
        StChk: begin
          if (fire) begin
            byte_ready_q <= 1'b0;
            if (bus.byte_data == sum_q) begin
              state_q     <= StDone;
              core_rst_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= StErr;
              load_err_q <= 1'b1;
            end
          end
        end
        StDone: state_q <= StDone;
        StErr:  state_q <= StErr;
        default: begin
          state_q      <= StErr;
          byte_ready_q <= 1'b0;
          load_err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.sram_en    = sram_en_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_din   = sram_din_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random boot images checked against a
// stream-level model of the expected SRAM writes and final status.
module tb_imem_loader;
  localparam int AW = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mem [256];
  wr_t         wlog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM model and write-strobe monitor
  always @(negedge clk) begin
    if (bus.sram_en === 1'b1) begin
      wr_t w;
      w.addr = bus.sram_addr;
      w.din  = bus.sram_din;
      wlog.push_back(w);
      mem[bus.sram_addr] = bus.sram_din;
      check("sram_we_in_write", 32'(bus.sram_we), 32'hF);
    end else begin
      check("sram_we_idle", 32'(bus.sram_we), 32'h0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wlog.delete();
  endtask

  // Presents the bytes in order with random idle gaps; counts cycles a byte was refused.
  task automatic send(input bq_t s, input int gap_pct, output int stalls);
    int i = 0;
    int cyc = 0;
    logic rdy;
    stalls = 0;
    while (i < s.size() && cyc < 20000) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.byte_valid = 1'b0;
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = s[i];
      end
      rdy = bus.byte_ready;
      @(posedge clk);
      cyc++;
      if (bus.byte_valid && rdy) i++;
      else if (bus.byte_valid) stalls++;
    end
    check("send_complete", i, s.size());
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic make_image(input int h, input bit corrupt, output bq_t s);
    logic [7:0] sum;
    logic [7:0] b;
    s.delete();
    s.push_back(h[7:0]);
    sum = h[7:0];
    for (int i = 0; i < 4 * (h + 1); i++) begin
      b = 8'($urandom);
      s.push_back(b);
      sum += b;
    end
    if (corrupt) sum += 8'($urandom_range(1, 255));
    s.push_back(sum);
  endtask

  // Model: word k is bytes 4k+1..4k+4 little-endian; image good iff checksum matches.
  task automatic check_result(input string tag, input bq_t s);
    int         h = int'(s[0]);
    logic [7:0] sum = 8'h0;
    bit         good;
    int         n;
    logic [31:0] exp_w;
    for (int i = 0; i < s.size() - 1; i++) sum += s[i];
    good = (sum == s[s.size() - 1]);
    check({tag, "_done"}, 32'(bus.load_done), 32'(good));
    check({tag, "_err"}, 32'(bus.load_err), 32'(!good));
    check({tag, "_core_rst"}, 32'(bus.core_rst), 32'(!good));
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'h0);
    check({tag, "_nwrites"}, wlog.size(), h + 1);
    n = (wlog.size() < h + 1) ? wlog.size() : h + 1;
    for (int k = 0; k < n; k++) begin
      exp_w = {s[4*k+4], s[4*k+3], s[4*k+2], s[4*k+1]};
      check({tag, "_addr"}, 32'(wlog[k].addr), k);
      check({tag, "_din"}, wlog[k].din, exp_w);
      check({tag, "_mem"}, mem[k], exp_w);
    end
  endtask

  initial begin
    bq_t        s;
    bq_t        part;
    int         st;
    logic [7:0] sum;
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h0;

    do_reset();
    check("rst_ready", 32'(bus.byte_ready), 32'h1);
    check("rst_core_rst", 32'(bus.core_rst), 32'h1);
    check("rst_done", 32'(bus.load_done), 32'h0);
    check("rst_err", 32'(bus.load_err), 32'h0);
    check("rst_sram_en", 32'(bus.sram_en), 32'h0);

    // Single-word image
    s = '{8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send(s, 0, st);
    check_result("one_word", s);
    if (wlog.size() > 0) check("one_word_din", wlog[0].din, 32'h00000013);

    // Two-word image, gap-free so a byte sits on the bus through each write cycle
    do_reset();
    s = '{8'h01, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    sum = 8'h0;
    foreach (s[i]) sum += s[i];
    s.push_back(sum);
    send(s, 0, st);
    check_result("two_word", s);
    check("write_stall_count", st, 2);
    if (wlog.size() > 1) begin
      check("two_word_w0", wlog[0].din, 32'h00100093);
      check("two_word_w1", wlog[1].din, 32'h00200113);
    end

    // Bad checksum: terminal error, nothing further consumed
    do_reset();
    s = '{8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    send(s, 0, st);
    check_result("bad_sum", s);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      check("err_no_accept", 32'(bus.byte_ready), 32'h0);
      check("err_sticky", 32'(bus.load_err), 32'h1);
      check("err_core_rst", 32'(bus.core_rst), 32'h1);
    end
    bus.byte_valid = 1'b0;

    // Full 256-word image with random gaps
    do_reset();
    make_image(255, 1'b0, s);
    send(s, 40, st);
    check_result("full", s);

    // Reset mid-load, then a fresh image
    do_reset();
    make_image(3, 1'b0, part);
    part = part[0:6];
    send(part, 20, st);
    check("partial_writes", wlog.size(), 1);
    do_reset();
    make_image(2, 1'b0, s);
    send(s, 20, st);
    check_result("after_rst", s);
    if (wlog.size() > 0) check("after_rst_first", wlog[0].din, {s[4], s[3], s[2], s[1]});

    // Random images, some with corrupted checksums
    for (int t = 0; t < 6; t++) begin
      do_reset();
      make_image(int'($urandom_range(15)), ($urandom_range(3) == 0), s);
      send(s, 30, st);
      check_result("rand", s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
